flip_game_ctrl: RTL and testbench

// Parametrised successor game controller for the bottle-flip display: holds NUM_SQ platforms,

---
 rtl/flip_game_ctrl_if.sv | 25 ++
 rtl/flip_game_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_flip_game_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/flip_game_ctrl_if.sv
// Render-side bundle of the bottle-flip game controller.
// Carries platform geometry, player position and score to the display.
interface flip_game_ctrl_if #(
    parameter int NUM_SQ  = 3,
    parameter int COORD_W = 8,
    parameter int SCORE_W = 8
);
    logic [NUM_SQ*COORD_W-1:0] sq_cx;
    logic [NUM_SQ*COORD_W-1:0] sq_cy;
    logic [NUM_SQ-1:0]         sq_color;
    logic [COORD_W-1:0]        pl_x;
    logic [COORD_W-1:0]        pl_y;
    logic [SCORE_W-1:0]        score;
    logic                      game_over;

    modport master (
        output sq_cx, sq_cy, sq_color,
        output pl_x, pl_y, score, game_over
    );

    modport slave (
        input sq_cx, sq_cy, sq_color,
        input pl_x, pl_y, score, game_over
    );
endinterface

// File: rtl/flip_game_ctrl.sv
// Bottle-flip game controller: charge, jump arc, scoring, platform scroll.
// Optional FLIP_PERFECT_BONUS_EN: exact landing scores 2 instead of 1.
module flip_game_ctrl #(
    parameter int NUM_SQ     = 3,
    parameter int COORD_W    = 8,
    parameter int RATIO_SFT  = 4,
    parameter int DIST_MIN   = 13,
    parameter int DIST_RND_W = 3,
    parameter int CHARGE_MAX = 31,
    parameter int HIT_TOL    = 2,
    parameter int SCORE_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        frame_tick,
    input  logic [15:0] rand_in,
    flip_game_ctrl_if.master gif
);
    localparam int XW  = NUM_SQ*COORD_W;
    localparam int PW  = COORD_W+RATIO_SFT+1;
    localparam int PW2 = COORD_W+RATIO_SFT+2;
    localparam int AW  = 2*COORD_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHARGE = 3'd1;
    localparam logic [2:0] S_JUMP   = 3'd2;
    localparam logic [2:0] S_LAND   = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic [COORD_W-1:0] BASE_X0 = COORD_W'(20);
    localparam logic [COORD_W-1:0] BASE_X1 = COORD_W'(40);
    localparam logic [COORD_W-1:0] BASE_Y  = COORD_W'(100);
    localparam logic [COORD_W-1:0] C_MAX   = COORD_W'(CHARGE_MAX);
    localparam logic [COORD_W-1:0] C_DMIN  = COORD_W'(DIST_MIN);
    localparam logic [COORD_W-1:0] C_TOL   = COORD_W'(HIT_TOL);
    localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
    localparam logic [RATIO_SFT:0] R_ONE   = (RATIO_SFT+1)'(1);

    function automatic logic [XW-1:0] geom_x(
        input logic [NUM_SQ-1:0] lay,
        input logic [XW-1:0]     gp
    );
        logic [XW-1:0]      r;
        logic [COORD_W-1:0] c;
        c = lay[0] ? BASE_X1 : BASE_X0;
        r = '0;
        r[0 +: COORD_W] = c;
        for (int i = 1; i < NUM_SQ; i++) begin
            if (lay[i-1])
                c = c - gp[(i-1)*COORD_W +: COORD_W];
            else
                c = c + gp[(i-1)*COORD_W +: COORD_W];
            r[i*COORD_W +: COORD_W] = c;
        end
        return r;
    endfunction

    function automatic logic [XW-1:0] geom_y(
        input logic [XW-1:0] gp
    );
        logic [XW-1:0]      r;
        logic [COORD_W-1:0] c;
        c = BASE_Y;
        r = '0;
        r[0 +: COORD_W] = c;
        for (int i = 1; i < NUM_SQ; i++) begin
            c = c - gp[(i-1)*COORD_W +: COORD_W];
            r[i*COORD_W +: COORD_W] = c;
        end
        return r;
    endfunction

    localparam logic [XW-1:0] RST_GAP = {NUM_SQ{C_DMIN}};
    localparam logic [XW-1:0] RST_CX  = geom_x('0, RST_GAP);
    localparam logic [XW-1:0] RST_CY  = geom_y(RST_GAP);

    logic [2:0]                state;
    logic                      btn_q;
    logic [NUM_SQ-1:0]         layout;
    logic [NUM_SQ-1:0]         color;
    logic [XW-1:0]             gap;
    logic [COORD_W-1:0]        charge;
    logic [RATIO_SFT:0]        ratio;
    logic [SCORE_W-1:0]        score;
    logic                      go_r;
    logic [XW-1:0]             cx_r;
    logic [XW-1:0]             cy_r;
    logic [COORD_W-1:0]        plx;
    logic [COORD_W-1:0]        ply;
    logic [COORD_W-1:0]        pls_x;
    logic [COORD_W-1:0]        pls_y;
    logic signed [COORD_W-1:0] dif_x;
    logic signed [COORD_W-1:0] dif_y;
    logic                      nxt_lay;
    logic                      nxt_col;
    logic [COORD_W-1:0]        nxt_gap;

    logic                      rise;
    logic [XW-1:0]             cur_cx;
    logic [XW-1:0]             cur_cy;
    logic [COORD_W-1:0]        cx0;
    logic [COORD_W-1:0]        cy0;
    logic [COORD_W-1:0]        gap0;
    logic [RATIO_SFT:0]        ratio_n;
    logic                      last;
    logic [PW-1:0]             prod;
    logic [COORD_W-1:0]        dx;
    logic [COORD_W-1:0]        cmd;
    logic [AW-1:0]             arc;
    logic [COORD_W-1:0]        jx;
    logic [COORD_W-1:0]        jy;
    logic [COORD_W-1:0]        adiff;
    logic                      hit;
    logic [SCORE_W:0]          sc_inc;
    logic [SCORE_W:0]          sc_sum;
    logic [SCORE_W-1:0]        score_n;
    logic signed [PW2-1:0]     offx_w;
    logic signed [PW2-1:0]     offy_w;
    logic [COORD_W-1:0]        offx;
    logic [COORD_W-1:0]        offy;
    logic [XW-1:0]             sh_cx;
    logic [XW-1:0]             sh_cy;
    logic [NUM_SQ-1:0]         new_lay;
    logic [NUM_SQ-1:0]         new_col;
    logic [XW-1:0]             new_gap;
    logic [XW-1:0]             new_cx;
    logic [XW-1:0]             new_cy;
    logic [COORD_W-1:0]        bx1;
    logic                      unused_ok;

    assign rise    = btn & ~btn_q;
    assign cur_cx  = geom_x(layout, gap);
    assign cur_cy  = geom_y(gap);
    assign cx0     = cur_cx[0 +: COORD_W];
    assign cy0     = cur_cy[0 +: COORD_W];
    assign gap0    = gap[0 +: COORD_W];
    assign ratio_n = ratio + R_ONE;
    assign last    = ratio_n[RATIO_SFT];

    // Jump arc: linear X, parabolic lift that returns to zero at dx == charge
    assign prod = PW'(charge) * PW'(ratio_n);
    assign dx   = prod[RATIO_SFT +: COORD_W];
    assign cmd  = charge - dx;
    assign arc  = AW'(dx) * AW'(cmd);
    assign jx   = layout[0] ? cx0 - dx : cx0 + dx;
    assign jy   = cy0 - dx - arc[2 +: COORD_W];

    assign adiff = (charge >= gap0) ? charge - gap0 : gap0 - charge;
    assign hit   = adiff <= C_TOL;

`ifdef FLIP_PERFECT_BONUS_EN
    assign sc_inc = (charge == gap0) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1);
`else
    assign sc_inc = (SCORE_W+1)'(1);
`endif
    assign sc_sum  = {1'b0, score} + sc_inc;
    assign score_n = sc_sum[SCORE_W] ? '1 : sc_sum[SCORE_W-1:0];

    assign bx1 = layout[1] ? BASE_X1 : BASE_X0;

    // Scroll offset is a signed fraction of the full displacement
    assign offx_w = PW2'(dif_x) * PW2'($signed({1'b0, ratio_n}));
    assign offy_w = PW2'(dif_y) * PW2'($signed({1'b0, ratio_n}));
    assign offx   = offx_w[RATIO_SFT +: COORD_W];
    assign offy   = offy_w[RATIO_SFT +: COORD_W];

    always_comb begin
        sh_cx = '0;
        sh_cy = '0;
        for (int i = 0; i < NUM_SQ; i++) begin
            sh_cx[i*COORD_W +: COORD_W] = cur_cx[i*COORD_W +: COORD_W] + offx;
            sh_cy[i*COORD_W +: COORD_W] = cur_cy[i*COORD_W +: COORD_W] + offy;
        end
    end

    assign new_lay = {nxt_lay, layout[NUM_SQ-1:1]};
    assign new_col = {nxt_col, color[NUM_SQ-1:1]};
    assign new_gap = {nxt_gap, gap[XW-1:COORD_W]};
    assign new_cx  = geom_x(new_lay, new_gap);
    assign new_cy  = geom_y(new_gap);

    assign unused_ok = ^{rand_in[15:5+DIST_RND_W],
                         prod[PW-1], prod[RATIO_SFT-1:0],
                         arc[AW-1:COORD_W+2], arc[1:0],
                         offx_w[PW2-1:PW2-2], offx_w[RATIO_SFT-1:0],
                         offy_w[PW2-1:PW2-2], offy_w[RATIO_SFT-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            btn_q   <= 1'b0;
            layout  <= '0;
            color   <= '0;
            gap     <= RST_GAP;
            charge  <= '0;
            ratio   <= '0;
            score   <= '0;
            go_r    <= 1'b0;
            cx_r    <= RST_CX;
            cy_r    <= RST_CY;
            plx     <= RST_CX[0 +: COORD_W];
            ply     <= RST_CY[0 +: COORD_W];
            pls_x   <= '0;
            pls_y   <= '0;
            dif_x   <= '0;
            dif_y   <= '0;
            nxt_lay <= 1'b0;
            nxt_col <= 1'b0;
            nxt_gap <= C_DMIN;
        end else begin
            btn_q <= btn;
            unique case (state)
                S_IDLE: begin
                    if (rise) begin
                        state  <= S_CHARGE;
                        charge <= '0;
                    end
                end
                S_CHARGE: begin
                    if (!btn) begin
                        state <= S_JUMP;
                        ratio <= '0;
                    end else if (frame_tick && charge < C_MAX) begin
                        charge <= charge + C_ONE;
                    end
                end
                S_JUMP: begin
                    if (frame_tick) begin
                        ratio <= ratio_n;
                        plx   <= jx;
                        ply   <= jy;
                        if (last)
                            state <= S_LAND;
                    end
                end
                S_LAND: begin
                    if (hit) begin
                        state   <= S_SHIFT;
                        score   <= score_n;
                        ratio   <= '0;
                        pls_x   <= plx;
                        pls_y   <= ply;
                        dif_x   <= bx1 - cur_cx[COORD_W +: COORD_W];
                        dif_y   <= BASE_Y - cur_cy[COORD_W +: COORD_W];
                        nxt_lay <= (rand_in[3:0] > 4'd13) ?
                                   layout[NUM_SQ-2] : ~layout[NUM_SQ-2];
                        nxt_col <= rand_in[4];
                        nxt_gap <= C_DMIN + COORD_W'(rand_in[5 +: DIST_RND_W]);
                    end else begin
                        state <= S_OVER;
                        go_r  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (frame_tick) begin
                        ratio <= ratio_n;
                        if (last) begin
                            state  <= S_IDLE;
                            layout <= new_lay;
                            color  <= new_col;
                            gap    <= new_gap;
                            cx_r   <= new_cx;
                            cy_r   <= new_cy;
                            plx    <= new_cx[0 +: COORD_W];
                            ply    <= new_cy[0 +: COORD_W];
                            charge <= '0;
                        end else begin
                            cx_r <= sh_cx;
                            cy_r <= sh_cy;
                            plx  <= pls_x + offx;
                            ply  <= pls_y + offy;
                        end
                    end
                end
                S_OVER: begin
                    if (rise) begin
                        state  <= S_IDLE;
                        layout <= '0;
                        color  <= '0;
                        gap    <= RST_GAP;
                        charge <= '0;
                        ratio  <= '0;
                        score  <= '0;
                        go_r   <= 1'b0;
                        cx_r   <= RST_CX;
                        cy_r   <= RST_CY;
                        plx    <= RST_CX[0 +: COORD_W];
                        ply    <= RST_CY[0 +: COORD_W];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign gif.sq_cx     = cx_r;
    assign gif.sq_cy     = cy_r;
    assign gif.sq_color  = color;
    assign gif.pl_x      = plx;
    assign gif.pl_y      = ply;
    assign gif.score     = score;
    assign gif.game_over = go_r;
endmodule

// File: tb/tb_flip_game_ctrl.sv
// Bench for flip_game_ctrl: jump table with scoreboard plus
// hand sequences for scrolling, game over and async reset.
module tb_flip_game_ctrl;
    logic        clk;
    logic        rst_n;
    logic        btn;
    logic        frame_tick;
    logic [15:0] rand_in;

`ifdef FLIP_PERFECT_BONUS_EN
    localparam int BONUS = 1;
`else
    localparam int BONUS = 0;
`endif

    flip_game_ctrl_if #(.NUM_SQ(3), .COORD_W(8), .SCORE_W(8)) gif ();

    flip_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .frame_tick (frame_tick),
        .rand_in    (rand_in),
        .gif        (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hold;
        int plx;
        int score;
        int over;
    } vec_t;

    vec_t vt[8];
    int   exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        btn = 1'b0;
        frame_tick = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic press(input int n);
        btn = 1'b1;
        cyc();
        repeat (n) tick();
        btn = 1'b0;
        cyc();
    endtask

    function automatic int sq(input logic [23:0] v, input int i);
        logic [23:0] t;
        t = v >> (8*i);
        return int'(t[7:0]);
    endfunction

    task automatic pop_chk(input string nm, input logic [31:0] act);
        int e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty actual=%0d", nm, act);
        end else begin
            e = exp_q.pop_front();
            chk(nm, act, e);
        end
    endtask

    initial begin
        int c;
        int h;
        vt[0] = '{13, 33, 1+BONUS, 0};
        vt[1] = '{5,  25, 0, 1};
        vt[2] = '{11, 31, 1, 0};
        vt[3] = '{15, 35, 1, 0};
        vt[4] = '{10, 30, 0, 1};
        vt[5] = '{16, 36, 0, 1};
        vt[6] = '{40, 51, 0, 1};
        vt[7] = '{14, 34, 1, 0};
        rand_in = 16'h0000;

        do_reset();
        chk("rst_sq0x", sq(gif.sq_cx, 0), 20);
        chk("rst_sq0y", sq(gif.sq_cy, 0), 100);
        chk("rst_sq1x", sq(gif.sq_cx, 1), 33);
        chk("rst_sq1y", sq(gif.sq_cy, 1), 87);
        chk("rst_sq2x", sq(gif.sq_cx, 2), 46);
        chk("rst_sq2y", sq(gif.sq_cy, 2), 74);
        chk("rst_plx", gif.pl_x, 20);
        chk("rst_ply", gif.pl_y, 100);
        chk("rst_score", gif.score, 0);
        chk("rst_over", gif.game_over, 0);
        chk("rst_color", gif.sq_color, 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            h = vt[i].hold;
            c = (h > 31) ? 31 : h;
            exp_q.push_back(20 + c);
            exp_q.push_back(((c - 13) <= 2 && (13 - c) <= 2) ? 1 + ((c == 13) ? BONUS : 0) : 0);
            exp_q.push_back(((c - 13) <= 2 && (13 - c) <= 2) ? 0 : 1);
            press(h);
            repeat (16) tick();
            pop_chk($sformatf("v%0d_plx", i), gif.pl_x);
            pop_chk($sformatf("v%0d_score", i), gif.score);
            pop_chk($sformatf("v%0d_over", i), gif.game_over);
            chk($sformatf("v%0d_tab_plx", i), gif.pl_x, vt[i].plx);
            chk($sformatf("v%0d_tab_score", i), gif.score, vt[i].score);
            if (vt[i].over == 0) begin
                repeat (16) tick();
                chk($sformatf("v%0d_shift_sq0x", i), sq(gif.sq_cx, 0), 20);
                chk($sformatf("v%0d_shift_plx", i), gif.pl_x, 20);
                chk($sformatf("v%0d_shift_ply", i), gif.pl_y, 100);
            end
        end

        // Full play: two hits with scroll, then miss and restart
        do_reset();
        rand_in = 16'h003F;
        press(13);
        repeat (8) tick();
        chk("mid_jump_plx", gif.pl_x, 26);
        chk("mid_jump_ply", gif.pl_y, 84);
        repeat (8) tick();
        chk("end_jump_ply", gif.pl_y, 87);
        rand_in = 16'h0000;
        repeat (8) tick();
        chk("mid_shift_sq0x", sq(gif.sq_cx, 0), 13);
        chk("mid_shift_sq0y", sq(gif.sq_cy, 0), 106);
        chk("mid_shift_sq1x", sq(gif.sq_cx, 1), 26);
        chk("mid_shift_plx", gif.pl_x, 26);
        chk("mid_shift_ply", gif.pl_y, 93);
        repeat (8) tick();
        chk("shift1_color", gif.sq_color, 3'b100);
        chk("shift1_sq2x", sq(gif.sq_cx, 2), 46);
        press(13);
        repeat (16) tick();
        chk("hit2_score", gif.score, 2 + 2*BONUS);
        repeat (16) tick();
        chk("shift2_color", gif.sq_color, 3'b010);
        chk("shift2_sq2x", sq(gif.sq_cx, 2), 47);
        chk("shift2_sq2y", sq(gif.sq_cy, 2), 73);
        press(5);
        repeat (16) tick();
        chk("miss_over", gif.game_over, 1);
        chk("miss_score_held", gif.score, 2 + 2*BONUS);
        repeat (3) tick();
        chk("over_frozen_plx", gif.pl_x, 25);
        btn = 1'b1;
        cyc();
        chk("restart_over", gif.game_over, 0);
        chk("restart_score", gif.score, 0);
        chk("restart_plx", gif.pl_x, 20);
        chk("restart_color", gif.sq_color, 0);
        btn = 1'b0;
        cyc();
        press(13);
        repeat (16) tick();
        chk("restart_hit", gif.score, 1 + BONUS);

        // Async reset in the middle of a scroll
        do_reset();
        rand_in = 16'h0010;
        press(13);
        repeat (16) tick();
        repeat (7) tick();
        chk("pre_arst_sq0x", sq(gif.sq_cx, 0), 14);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sq0x", sq(gif.sq_cx, 0), 20);
        chk("arst_score", gif.score, 0);
        chk("arst_plx", gif.pl_x, 20);
        chk("arst_color", gif.sq_color, 0);
        rst_n = 1'b1;
        cyc();
        repeat (10) tick();
        chk("arst_no_commit_color", gif.sq_color, 0);
        chk("arst_idle_sq0x", sq(gif.sq_cx, 0), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
